// File: rtl/psum_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module : psum_accumulator_if
// Brief  : Partial-sum input stream and result output stream for one column.
// Rev    : 1.0  initial release
// ============================================================================
interface psum_accumulator_if #(
    parameter int P_BITWIDTH   = 24,
    parameter int ACC_BITWIDTH = 32
);
    logic                    p_valid;
    logic [P_BITWIDTH-1:0]   p_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [ACC_BITWIDTH-1:0] out_data;
    logic                    out_last;

    // master is the surrounding array/downstream side, slave is the accumulator
    modport master (
        output p_valid, p_in, out_ready,
        input  out_valid, out_data, out_last
    );
    modport slave (
        input  p_valid, p_in, out_ready,
        output out_valid, out_data, out_last
    );
endinterface
`default_nettype wire

// File: rtl/psum_accumulator.sv
`default_nettype none
// ============================================================================
// Module : psum_accumulator
// Brief  : Accumulates column partial sums across K-tiles in a row buffer and
//          drains the results over valid/ready. Optional macro: ACC_SAT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module psum_accumulator #(
    parameter int P_BITWIDTH   = 24,
    parameter int ACC_BITWIDTH = 32,
    parameter int DEPTH        = 16,
    localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          start,
    input  wire logic [AW:0]   rows_cfg,
    input  wire logic [7:0]    tiles_cfg,
    output logic               busy,
    output logic               done,
    output logic               dropped,
    output logic               sat_flag,
    psum_accumulator_if.slave  bus
);

    localparam logic [AW:0]   ROWS_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_R    = 1;
    localparam logic [AW-1:0] ONE_P    = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [AW:0]             rows;
    logic [7:0]              tiles;
    logic [7:0]              tile_cnt;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW-1:0]           rd_next;
    logic [ACC_BITWIDTH-1:0] row_buf [DEPTH];
    logic [ACC_BITWIDTH-1:0] p_ext;
    logic [ACC_BITWIDTH-1:0] wr_data;
    logic                    cfg_ok;
    logic                    accept;
    logic                    acc_en;
    logic                    wr_last;
    logic                    tile_last;
    logic                    hs;
    logic                    drain_end;

    assign busy = (state != IDLE);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        acc_en    = 1'b0;
        drain_end = 1'b0;
        cfg_ok    = (rows_cfg != '0) && (rows_cfg <= ROWS_MAX) && (tiles_cfg != 8'd0);
        wr_last   = ({1'b0, wr_ptr} == (rows - ONE_R));
        tile_last = (tile_cnt == (tiles - 8'd1));
        hs        = bus.out_valid && bus.out_ready;
        rd_next   = rd_ptr + ONE_P;
        case (state)
            IDLE: begin
                if (start && cfg_ok) begin
                    accept    = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (bus.p_valid) begin
                    acc_en = 1'b1;
                    if (wr_last && tile_last) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (hs && bus.out_last) begin
                    drain_end = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef ACC_SAT_EN
    logic [ACC_BITWIDTH:0] sum_full;
    logic                  sat_hit;

    always_comb begin
        p_ext    = ACC_BITWIDTH'(bus.p_in);
        sum_full = {1'b0, row_buf[wr_ptr]} + {1'b0, p_ext};
        sat_hit  = sum_full[ACC_BITWIDTH] && (tile_cnt != 8'd0);
        if (tile_cnt == 8'd0) begin
            wr_data = p_ext;
        end else if (sat_hit) begin
            wr_data = '1;
        end else begin
            wr_data = sum_full[ACC_BITWIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= 1'b0;
        end else if (accept) begin
            sat_flag <= 1'b0;
        end else if (acc_en && sat_hit) begin
            sat_flag <= 1'b1;
        end
    end
`else
    always_comb begin
        p_ext   = ACC_BITWIDTH'(bus.p_in);
        wr_data = (tile_cnt == 8'd0) ? p_ext : (row_buf[wr_ptr] + p_ext);
    end

    assign sat_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Buffer has no reset: the first tile of every job overwrites each row.
    always_ff @(posedge clk) begin
        if (acc_en) begin
            row_buf[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rows          <= '0;
            tiles         <= 8'd0;
            tile_cnt      <= 8'd0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            done          <= 1'b0;
            dropped       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            done <= drain_end;

            if (accept) begin
                rows     <= rows_cfg;
                tiles    <= tiles_cfg;
                tile_cnt <= 8'd0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                dropped  <= 1'b0;
            end else if (bus.p_valid && (state != ACCUM)) begin
                dropped <= 1'b1;
            end

            if (acc_en) begin
                if (wr_last) begin
                    wr_ptr   <= '0;
                    tile_cnt <= tile_cnt + 8'd1;
                    if (tile_last) begin
                        // A single-row job reads the word being written this edge.
                        bus.out_valid <= 1'b1;
                        bus.out_data  <= (rows == ONE_R) ? wr_data : row_buf[0];
                        bus.out_last  <= (rows == ONE_R);
                        rd_ptr        <= '0;
                    end
                end else begin
                    wr_ptr <= wr_ptr + ONE_P;
                end
            end

            if ((state == DRAIN) && hs) begin
                if (bus.out_last) begin
                    bus.out_valid <= 1'b0;
                    bus.out_last  <= 1'b0;
                end else begin
                    rd_ptr       <= rd_next;
                    bus.out_data <= row_buf[rd_next];
                    bus.out_last <= ({1'b0, rd_next} == (rows - ONE_R));
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psum_accumulator.sv
`default_nettype none
// ============================================================================
// Module : tb_psum_accumulator
// Brief  : Scoreboard bench for psum_accumulator (ACC_BITWIDTH=25).
// Rev    : 1.0  initial release
// ============================================================================
module tb_psum_accumulator;
    localparam int P     = 24;
    localparam int ACC   = 25;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   rows_cfg;
    logic [7:0]    tiles_cfg;
    logic          busy;
    logic          done;
    logic          dropped;
    logic          sat_flag;

    psum_accumulator_if #(.P_BITWIDTH(P), .ACC_BITWIDTH(ACC)) bus ();

    psum_accumulator #(
        .P_BITWIDTH   (P),
        .ACC_BITWIDTH (ACC),
        .DEPTH        (DEPTH)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rows_cfg  (rows_cfg),
        .tiles_cfg (tiles_cfg),
        .busy      (busy),
        .done      (done),
        .dropped   (dropped),
        .sat_flag  (sat_flag),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;
    bit   mon_en      = 1'b0;
    bit   pending_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Output monitor: compares every accepted word and the done pulse timing.
    always @(negedge clk) begin
        if (mon_en) begin
            if (pending_done) begin
                check("done_pulse", {31'd0, done}, 32'd1);
                pending_done = 1'b0;
            end else begin
                check("done_quiet", {31'd0, done}, 32'd0);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_data", 32'(bus.out_data), mon_e.data);
                    check("out_last", {31'd0, bus.out_last}, {31'd0, mon_e.last});
                    if (mon_e.last) pending_done = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input bit l);
        exp_t e;
        e.data = d;
        e.last = l;
        sb.push_back(e);
    endtask

    task automatic start_job(input int r, input int t);
        start     = 1'b1;
        rows_cfg  = r[AW:0];
        tiles_cfg = t[7:0];
        tick();
        start     = 1'b0;
    endtask

    task automatic feed(input logic [P-1:0] v);
        bus.p_valid = 1'b1;
        bus.p_in    = v;
        tick();
        bus.p_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit rnd);
        int n = 0;
        while (busy && n < budget) begin
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        bus.out_ready = 1'b1;
        check("job_end_busy", {31'd0, busy}, 32'd0);
        tick();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a [DEPTH];
        logic [31:0] b [DEPTH];

        rst = 1'b1; start = 1'b0; rows_cfg = '0; tiles_cfg = '0;
        bus.p_valid = 1'b0; bus.p_in = '0; bus.out_ready = 1'b1;
        repeat (2) tick();
        check("rst_busy",      {31'd0, busy},          32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_last",  {31'd0, bus.out_last},  32'd0);
        check("rst_done",      {31'd0, done},          32'd0);
        check("rst_dropped",   {31'd0, dropped},       32'd0);
        check("rst_sat_flag",  {31'd0, sat_flag},      32'd0);
        check("rst_out_data",  32'(bus.out_data),      32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Single tile, back-to-back inputs
        start_job(4, 1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        push(1, 0); push(2, 0); push(3, 0); push(4, 1);
        for (int i = 1; i <= 4; i++) feed(P'(i));
        check("t1_latency_valid", {31'd0, bus.out_valid}, 32'd1);
        wait_idle(20, 0);

        // Two tiles with gaps between valids
        start_job(3, 2);
        push(11, 0); push(22, 0); push(33, 1);
        feed(10); tick(); feed(20); feed(30); tick(); tick();
        feed(1); feed(2); tick(); feed(3);
        wait_idle(20, 0);

        // Backpressure holds the first word
        bus.out_ready = 1'b0;
        start_job(2, 1);
        push(7, 0); push(9, 1);
        feed(7); feed(9);
        for (int i = 0; i < 3; i++) begin
            check("t3_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("t3_hold_data",  32'(bus.out_data),      32'd7);
            tick();
        end
        bus.out_ready = 1'b1;
        wait_idle(20, 0);

        // Start during ACCUM and p_valid during DRAIN are both ignored
        start_job(2, 1);
        push(6, 0); push(8, 1);
        feed(6);
        start = 1'b1; rows_cfg = 5'd5; tiles_cfg = 8'd3;
        tick();
        start = 1'b0;
        bus.out_ready = 1'b0;
        feed(8);
        bus.p_valid = 1'b1; bus.p_in = 24'd5;
        tick();
        bus.p_valid = 1'b0;
        check("t4_dropped_set", {31'd0, dropped},  32'd1);
        check("t4_data_kept",   32'(bus.out_data), 32'd6);
        bus.out_ready = 1'b1;
        wait_idle(20, 0);
        check("t4_dropped_sticky", {31'd0, dropped}, 32'd1);

        // Illegal configurations are refused
        start_job(0, 1);
        check("illegal_rows0", {31'd0, busy}, 32'd0);
        start_job(DEPTH + 1, 1);
        check("illegal_rows_big", {31'd0, busy}, 32'd0);
        start_job(3, 0);
        check("illegal_tiles0", {31'd0, busy}, 32'd0);
        check("illegal_keeps_dropped", {31'd0, dropped}, 32'd1);

        // Reset mid-job, then a clean job
        start_job(4, 1);
        check("t5_dropped_clear", {31'd0, dropped}, 32'd0);
        feed(100); feed(200);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_busy",      {31'd0, busy},          32'd0);
        check("t5_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        repeat (3) tick();
        start_job(2, 1);
        push(3, 0); push(4, 1);
        feed(3); feed(4);
        wait_idle(20, 0);

        // Overflow across three tiles of a single row
        start_job(1, 3);
`ifdef ACC_SAT_EN
        push(32'h1FF_FFFF, 1);
`else
        push(32'h0FF_FFFD, 1);
`endif
        feed(24'hFF_FFFF); feed(24'hFF_FFFF); feed(24'hFF_FFFF);
        wait_idle(20, 0);
`ifdef ACC_SAT_EN
        check("t6_sat_flag", {31'd0, sat_flag}, 32'd1);
`else
        check("t6_sat_flag", {31'd0, sat_flag}, 32'd0);
`endif

        // Full-depth job with random gaps and random backpressure
        start_job(DEPTH, 2);
        check("t7_sat_cleared", {31'd0, sat_flag}, 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            a[i] = 32'($urandom_range(0, 24'hFF_FFFF));
            b[i] = 32'($urandom_range(0, 24'hFF_FFFF));
            push((a[i] + b[i]) & 32'h1FF_FFFF, (i == DEPTH - 1));
        end
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if ($urandom_range(0, 3) == 0) tick();
                feed((t == 0) ? a[i][P-1:0] : b[i][P-1:0]);
            end
        end
        wait_idle(400, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
